// File: rtl/regfile_arbiter_if.sv
// Bundles the two requester command/response channels and the register file control bus.
// The slave modport is the arbiter's view; the master modport is the clients/register-file side.
interface regfile_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          a_req;
    logic          a_wr;
    logic [AW-1:0] a_wsel;
    logic [DW-1:0] a_wdata;
    logic [AW-1:0] a_rsel1;
    logic [AW-1:0] a_rsel2;
    logic          a_done;
    logic [DW-1:0] a_rdata1;
    logic [DW-1:0] a_rdata2;

    logic          b_req;
    logic          b_wr;
    logic [AW-1:0] b_wsel;
    logic [DW-1:0] b_wdata;
    logic [AW-1:0] b_rsel1;
    logic [AW-1:0] b_rsel2;
    logic          b_done;
    logic [DW-1:0] b_rdata1;
    logic [DW-1:0] b_rdata2;

    logic          busy;
    logic          gnt_b;

    logic          rf_en;
    logic          rf_wr;
    logic          rf_rd;
    logic [DW-1:0] rf_ip;
    logic [AW-1:0] rf_sel_i;
    logic [AW-1:0] rf_sel_o1;
    logic [AW-1:0] rf_sel_o2;
    logic [DW-1:0] rf_op1;
    logic [DW-1:0] rf_op2;

    modport slave (
        input  a_req, a_wr, a_wsel, a_wdata, a_rsel1, a_rsel2,
        input  b_req, b_wr, b_wsel, b_wdata, b_rsel1, b_rsel2,
        input  rf_op1, rf_op2,
        output a_done, a_rdata1, a_rdata2,
        output b_done, b_rdata1, b_rdata2,
        output busy, gnt_b,
        output rf_en, rf_wr, rf_rd, rf_ip, rf_sel_i, rf_sel_o1, rf_sel_o2
    );

    modport master (
        output a_req, a_wr, a_wsel, a_wdata, a_rsel1, a_rsel2,
        output b_req, b_wr, b_wsel, b_wdata, b_rsel1, b_rsel2,
        output rf_op1, rf_op2,
        input  a_done, a_rdata1, a_rdata2,
        input  b_done, b_rdata1, b_rdata2,
        input  busy, gnt_b,
        input  rf_en, rf_wr, rf_rd, rf_ip, rf_sel_i, rf_sel_o1, rf_sel_o2
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer for two clients of a 16x32 register file (write or dual read).
// Latency: write done 1 cycle after grant, read done 3 cycles after grant; one IDLE cycle between transactions.
// Backpressure: requesters hold req until done; the loser and any req arriving while busy wait for IDLE.
module regfile_arbiter #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic             CLK,
    input  logic             rst,
    regfile_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t        state;
    logic          prio_b;

    logic          pick_b;
    logic          sel_wr;
    logic [AW-1:0] sel_wsel;
    logic [DW-1:0] sel_wdata;
    logic [AW-1:0] sel_rsel1;
    logic [AW-1:0] sel_rsel2;

    // B wins only if A is absent or B holds the round-robin priority.
    always_comb begin
        pick_b    = bus.b_req && (!bus.a_req || prio_b);
        sel_wr    = pick_b ? bus.b_wr    : bus.a_wr;
        sel_wsel  = pick_b ? bus.b_wsel  : bus.a_wsel;
        sel_wdata = pick_b ? bus.b_wdata : bus.a_wdata;
        sel_rsel1 = pick_b ? bus.b_rsel1 : bus.a_rsel1;
        sel_rsel2 = pick_b ? bus.b_rsel2 : bus.a_rsel2;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            prio_b        <= 1'b0;
            bus.busy      <= 1'b0;
            bus.gnt_b     <= 1'b0;
            bus.a_done    <= 1'b0;
            bus.b_done    <= 1'b0;
            bus.a_rdata1  <= '0;
            bus.a_rdata2  <= '0;
            bus.b_rdata1  <= '0;
            bus.b_rdata2  <= '0;
            bus.rf_en     <= 1'b0;
            bus.rf_wr     <= 1'b0;
            bus.rf_rd     <= 1'b0;
            bus.rf_ip     <= '0;
            bus.rf_sel_i  <= '0;
            bus.rf_sel_o1 <= '0;
            bus.rf_sel_o2 <= '0;
        end else begin
            bus.a_done <= 1'b0;
            bus.b_done <= 1'b0;
            bus.rf_en  <= 1'b0;
            bus.rf_wr  <= 1'b0;
            bus.rf_rd  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.a_req || bus.b_req) begin
                        bus.busy  <= 1'b1;
                        bus.gnt_b <= pick_b;
                        prio_b    <= !pick_b;
                        bus.rf_en <= 1'b1;
                        // The rf select/data registers double as the latched command.
                        if (sel_wr) begin
                            state        <= WRITE;
                            bus.rf_wr    <= 1'b1;
                            bus.rf_ip    <= sel_wdata;
                            bus.rf_sel_i <= sel_wsel;
                            bus.a_done   <= !pick_b;
                            bus.b_done   <= pick_b;
                        end else begin
                            state         <= READ;
                            bus.rf_rd     <= 1'b1;
                            bus.rf_sel_o1 <= sel_rsel1;
                            bus.rf_sel_o2 <= sel_rsel2;
                        end
                    end
                end
                WRITE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    // Register file outputs are valid now; done follows with the data already in place.
                    state <= RESP;
                    if (bus.gnt_b) begin
                        bus.b_rdata1 <= bus.rf_op1;
                        bus.b_rdata2 <= bus.rf_op2;
                        bus.b_done   <= 1'b1;
                    end else begin
                        bus.a_rdata1 <= bus.rf_op1;
                        bus.a_rdata2 <= bus.rf_op2;
                        bus.a_done   <= 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 16x32 register file on the rf bus.
module tb_regfile_arbiter;
    logic CLK;
    logic rst;

    regfile_arbiter_if #(.DW(32), .AW(4)) bus ();

    regfile_arbiter #(.DW(32), .AW(4)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Register file: write commits and read outputs register on the clock edge.
    logic [31:0] mem [16];
    always @(posedge CLK) begin
        if (bus.rf_en && bus.rf_wr) mem[bus.rf_sel_i] <= bus.rf_ip;
        if (bus.rf_en && bus.rf_rd) begin
            bus.rf_op1 <= mem[bus.rf_sel_o1];
            bus.rf_op2 <= mem[bus.rf_sel_o2];
        end
    end

    int cyc_no = 0;
    always @(posedge CLK) cyc_no <= cyc_no + 1;

    int rd_cnt = 0, wr_cnt = 0, en_cnt = 0, done_cnt = 0, ovl = 0;
    always @(negedge CLK) begin
        if (bus.rf_rd) rd_cnt++;
        if (bus.rf_wr) wr_cnt++;
        if (bus.rf_en) en_cnt++;
        if (bus.a_done || bus.b_done) done_cnt++;
        if (bus.a_done && bus.b_done) ovl++;
        if (bus.a_done && bus.gnt_b) ovl++;
        if (bus.b_done && !bus.gnt_b) ovl++;
        if (bus.rf_wr && bus.rf_rd) ovl++;
    end

    logic [31:0] snap_ip;
    logic [3:0]  snap_sel;
    logic        snap_wr, snap_en;

    task automatic txn(input bit who, input bit wr, input logic [3:0] ws, input logic [31:0] wd,
                       input logic [3:0] r1, input logic [3:0] r2, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        @(posedge CLK); #1;
        if (!who) begin
            bus.a_wr = wr; bus.a_wsel = ws; bus.a_wdata = wd; bus.a_rsel1 = r1; bus.a_rsel2 = r2; bus.a_req = 1'b1;
        end else begin
            bus.b_wr = wr; bus.b_wsel = ws; bus.b_wdata = wd; bus.b_rsel1 = r1; bus.b_rsel2 = r2; bus.b_req = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            cyc++;
            if (who ? bus.b_done : bus.a_done) begin
                got      = 1'b1;
                snap_ip  = bus.rf_ip;
                snap_sel = bus.rf_sel_i;
                snap_wr  = bus.rf_wr;
                snap_en  = bus.rf_en;
            end
        end
        chk("done_seen", {31'b0, got}, 32'd1);
        @(posedge CLK); #1;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n, base;
        int t[3];
        bit who_q[4];
        bit gb_q[4];
        bit first_b;
        bit got;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        bus.rf_op1 = '0; bus.rf_op2 = '0;
        bus.a_req = 0; bus.a_wr = 0; bus.a_wsel = 0; bus.a_wdata = 0; bus.a_rsel1 = 0; bus.a_rsel2 = 0;
        bus.b_req = 0; bus.b_wr = 0; bus.b_wsel = 0; bus.b_wdata = 0; bus.b_rsel1 = 0; bus.b_rsel2 = 0;
        rst = 1'b0;
        #13;
        chk("rst_busy",   {31'b0, bus.busy},  32'd0);
        chk("rst_gnt_b",  {31'b0, bus.gnt_b}, 32'd0);
        chk("rst_done",   {30'b0, bus.a_done, bus.b_done}, 32'd0);
        chk("rst_rf_ctl", {29'b0, bus.rf_en, bus.rf_wr, bus.rf_rd}, 32'd0);
        chk("rst_rdata",  bus.a_rdata1 | bus.a_rdata2 | bus.b_rdata1 | bus.b_rdata2, 32'd0);
        @(negedge CLK); rst = 1'b1;

        // Both requesters held: writes must alternate A, B, A, B from reset.
        @(posedge CLK); #1;
        bus.a_wr = 1; bus.a_wsel = 4'd2; bus.a_wdata = 32'h11111111;
        bus.b_wr = 1; bus.b_wsel = 4'd3; bus.b_wdata = 32'h22222222;
        bus.a_req = 1; bus.b_req = 1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge CLK);
            if (bus.a_done || bus.b_done) begin
                who_q[n] = bus.b_done;
                gb_q[n]  = bus.gnt_b;
                n++;
            end
        end
        @(posedge CLK); #1;
        bus.a_req = 0; bus.b_req = 0;
        chk("rr_count", n, 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_owner%0d", k), {31'b0, who_q[k]}, k % 2);
            chk($sformatf("rr_gnt_b%0d", k), {31'b0, gb_q[k]},  k % 2);
        end

        // Write A, write B, then A reads both.
        txn(0, 1, 4'd0, 32'hABCDEFAB, 4'd0, 4'd0, c);
        chk("wr_a_lat", c, 32'd2);
        txn(1, 1, 4'd1, 32'h01234567, 4'd0, 4'd0, c);
        chk("wr_b_lat", c, 32'd2);
        txn(0, 0, 4'd0, 32'h0, 4'd0, 4'd1, c);
        chk("rd_a_lat",  c, 32'd4);
        chk("rd_a_d1",   bus.a_rdata1, 32'hABCDEFAB);
        chk("rd_a_d2",   bus.a_rdata2, 32'h01234567);
        chk("b_rd_idle", bus.b_rdata1, 32'h0);

        // Cross-requester read-after-write.
        txn(0, 1, 4'd5, 32'hDEADBEEF, 4'd0, 4'd0, c);
        txn(1, 0, 4'd0, 32'h0, 4'd5, 4'd5, c);
        chk("raw_b_d1", bus.b_rdata1, 32'hDEADBEEF);
        chk("raw_b_d2", bus.b_rdata2, 32'hDEADBEEF);
        chk("raw_a_d1", bus.a_rdata1, 32'hABCDEFAB);
        chk("raw_a_d2", bus.a_rdata2, 32'h01234567);

        // B holds req through three reads of r1.
        @(posedge CLK); #1;
        bus.b_wr = 0; bus.b_rsel1 = 4'd1; bus.b_rsel2 = 4'd1; bus.b_req = 1;
        base = rd_cnt;
        c = wr_cnt;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge CLK);
            if (bus.b_done) begin
                t[n] = cyc_no;
                n++;
            end
        end
        @(posedge CLK); #1;
        bus.b_req = 0;
        chk("held_count", n, 32'd3);
        chk("held_gap1", t[1] - t[0], 32'd4);
        chk("held_gap2", t[2] - t[1], 32'd4);
        chk("held_rd_cycles", rd_cnt - base, 32'd3);
        chk("held_wr_cycles", wr_cnt - c, 32'd0);
        chk("held_b_d1", bus.b_rdata1, 32'h01234567);

        // Write strobe timing and rdata retention.
        base = wr_cnt;
        n = en_cnt;
        txn(0, 1, 4'd7, 32'h5A5A5A5A, 4'd0, 4'd0, c);
        chk("wt_lat",     c, 32'd2);
        chk("wt_ip",      snap_ip, 32'h5A5A5A5A);
        chk("wt_sel",     {28'b0, snap_sel}, 32'd7);
        chk("wt_strobe",  {30'b0, snap_en, snap_wr}, 32'd3);
        chk("wt_wr_cyc",  wr_cnt - base, 32'd1);
        chk("wt_en_cyc",  en_cnt - n, 32'd1);
        chk("wt_keep_d1", bus.a_rdata1, 32'hABCDEFAB);
        chk("wt_keep_d2", bus.a_rdata2, 32'h01234567);

        // Reset during CAPT of an A read; priority is B beforehand.
        @(posedge CLK); #1;
        bus.a_wr = 0; bus.a_rsel1 = 4'd5; bus.a_rsel2 = 4'd7; bus.a_req = 1;
        @(posedge CLK);
        @(posedge CLK); #2;
        chk("capt_busy", {31'b0, bus.busy}, 32'd1);
        base = done_cnt;
        rst = 1'b0;
        #1;
        chk("mr_busy",  {31'b0, bus.busy}, 32'd0);
        chk("mr_rdata", bus.a_rdata1 | bus.a_rdata2 | bus.b_rdata1 | bus.b_rdata2, 32'd0);
        chk("mr_rf",    {29'b0, bus.rf_en, bus.rf_wr, bus.rf_rd} | {28'b0, bus.rf_sel_o1} | bus.rf_ip, 32'd0);
        chk("mr_done",  {30'b0, bus.a_done, bus.b_done}, 32'd0);
        bus.a_req = 0;
        repeat (3) @(negedge CLK);
        rst = 1'b1;
        repeat (3) @(negedge CLK);
        chk("mr_no_done", done_cnt - base, 32'd0);
        @(posedge CLK); #1;
        bus.a_wr = 1; bus.a_wsel = 4'd8; bus.a_wdata = 32'h1;
        bus.b_wr = 1; bus.b_wsel = 4'd9; bus.b_wdata = 32'h2;
        bus.a_req = 1; bus.b_req = 1;
        got = 1'b0;
        first_b = 1'b1;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if (bus.a_done || bus.b_done) begin
                got = 1'b1;
                first_b = bus.b_done;
            end
        end
        @(posedge CLK); #1;
        bus.a_req = 0; bus.b_req = 0;
        chk("post_rst_first_a", {30'b0, got, first_b}, 32'd2);

        repeat (6) @(posedge CLK);
        chk("protocol_violations", ovl, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
